axi_stream_wr_master: RTL

Command-driven AXI4 write master that feeds the team's AXI BRAM slave.
- Accepts a (start address, beat count) command and streams input data words into AXI write bursts.
- Splits the transfer into bursts of at most MAX_BURST beats, never crossing a 4 KB boundary.
- Keeps one burst outstanding at a time and pulses done when the final write response returns.

---
 rtl/axi_wr_pkg.sv | 33 +++
 rtl/axi_burst_len_calc.sv | 35 +++
 rtl/axi_stream_wr_master.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/axi_wr_pkg.sv
// Shared types and constants for the AXI stream write master.
// Latency: none (declarations only).
// Backpressure: n/a.
package axi_wr_pkg;

  // Controller states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AW   = 3'd1,
    ST_W    = 3'd2,
    ST_B    = 3'd3,
    ST_DONE = 3'd4
  } wr_state_e;

  // AXI bursts may not cross this byte boundary
  localparam int AXI_4KB = 4096;

  // AXI write response codes
  localparam logic [1:0] BRESP_OKAY   = 2'd0;
  localparam logic [1:0] BRESP_SLVERR = 2'd2;
  localparam logic [1:0] BRESP_DECERR = 2'd3;

  // Ceiling log2, used to turn beat counts into byte offsets by shifting
  function automatic int clog2_int(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axi_burst_len_calc.sv
// Burst length = min(remaining, MAX_BURST, beats left before the next 4 KB boundary).
// Latency: purely combinational.
// Backpressure: none; the result follows the inputs.
module axi_burst_len_calc
  import axi_wr_pkg::*;
#(
  parameter int BPB       = 32,
  parameter int MAX_BURST = 16
) (
  input  logic [11:0] addr_lo_i,
  input  logic [15:0] remaining_i,
  output logic [8:0]  blen_o
);

  localparam int LOG2_BPB = clog2_int(BPB);

  logic [12:0] room_bytes;
  logic [16:0] room_beats;
  logic [16:0] rem_w;
  logic [16:0] max_w;
  logic [16:0] min_rm;
  logic [16:0] min_all;

  // Compare at 17 bits so a remaining count of 256 or more never truncates
  always_comb begin
    room_bytes = 13'(AXI_4KB) - {1'b0, addr_lo_i};
    room_beats = 17'(room_bytes >> LOG2_BPB);
    rem_w      = {1'b0, remaining_i};
    max_w      = 17'(MAX_BURST);
    min_rm     = (rem_w < max_w) ? rem_w : max_w;
    min_all    = (min_rm < room_beats) ? min_rm : room_beats;
    blen_o     = 9'(min_all);
  end

endmodule

// File: rtl/axi_stream_wr_master.sv
// Command-driven AXI4 write master: splits a beat count into 4 KB-safe bursts fed from a stream.
// Latency: AW one cycle after command accept or after each B; done one cycle after the last B.
// Backpressure: s_tready follows m_axi_wready in the data phase; one burst outstanding at a time.
// Optional: define AXI_WR_RESP_CHK_EN to abort on a bad BRESP/BID and report done_err.
module axi_stream_wr_master
  import axi_wr_pkg::*;
#(
  parameter int AXI_IDWIDTH = 4,
  parameter int AXI_AWIDTH  = 64,
  parameter int AXI_DWIDTH  = 256,
  parameter int MAX_BURST   = 16,
  parameter int WR_ID       = 0
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [AXI_AWIDTH-1:0]     cmd_addr,
  input  logic [15:0]               cmd_beats,
  input  logic                      s_tvalid,
  output logic                      s_tready,
  input  logic [AXI_DWIDTH-1:0]     s_tdata,
  output logic                      done,
  output logic                      done_err,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [AXI_AWIDTH-1:0]     m_axi_awaddr,
  output logic [7:0]                m_axi_awlen,
  output logic [AXI_IDWIDTH-1:0]    m_axi_awid,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  output logic                      m_axi_wlast,
  output logic [AXI_DWIDTH-1:0]     m_axi_wdata,
  output logic [AXI_DWIDTH/8-1:0]   m_axi_wstrb,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  input  logic [AXI_IDWIDTH-1:0]    m_axi_bid,
  input  logic [1:0]                m_axi_bresp
);

  localparam int BPB      = AXI_DWIDTH / 8;
  localparam int LOG2_BPB = clog2_int(BPB);
  localparam logic [AXI_AWIDTH-1:0] ALIGN_MASK = ~AXI_AWIDTH'(BPB - 1);

  wr_state_e             state_q, state_d;
  logic [AXI_AWIDTH-1:0] addr_q, addr_d;
  logic [15:0]           remaining_q, remaining_d;
  logic [8:0]            blen_q, blen_d;
  logic [7:0]            beat_q, beat_d;
  logic                  err_q, err_d;

  logic [8:0]            blen_calc;
  logic [15:0]           rem_after;
  logic [AXI_AWIDTH-1:0] addr_after;
  logic                  resp_bad;

  axi_burst_len_calc #(
    .BPB       (BPB),
    .MAX_BURST (MAX_BURST)
  ) u_blen (
    .addr_lo_i   (addr_q[11:0]),
    .remaining_i (remaining_q),
    .blen_o      (blen_calc)
  );

  // Address wraps silently at the full AXI address width
  assign addr_after = addr_q + (AXI_AWIDTH'(blen_q) << LOG2_BPB);
  assign rem_after  = remaining_q - 16'(blen_q);

`ifdef AXI_WR_RESP_CHK_EN
  assign resp_bad = (m_axi_bresp != BRESP_OKAY) || (m_axi_bid != AXI_IDWIDTH'(WR_ID));
`else
  logic unused_resp;
  assign unused_resp = ^{m_axi_bresp, m_axi_bid};
  assign resp_bad    = 1'b0;
`endif

  // Constant and pass-through AXI fields
  assign m_axi_awaddr = addr_q;
  assign m_axi_awlen  = 8'(blen_calc - 9'd1);
  assign m_axi_awid   = AXI_IDWIDTH'(WR_ID);
  assign m_axi_wdata  = s_tdata;
  assign m_axi_wstrb  = '1;

  // State and transfer bookkeeping registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      blen_q      <= '0;
      beat_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      blen_q      <= blen_d;
      beat_q      <= beat_d;
      err_q       <= err_d;
    end
  end

  // Next-state and handshake outputs; blen is latched at AW so B can advance by it
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    remaining_d   = remaining_q;
    blen_d        = blen_q;
    beat_d        = beat_q;
    err_d         = err_q;
    cmd_ready     = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    s_tready      = 1'b0;
    m_axi_wlast   = 1'b0;
    m_axi_bready  = 1'b0;
    done          = 1'b0;
    done_err      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d      = cmd_addr & ALIGN_MASK;
          remaining_d = cmd_beats;
          err_d       = 1'b0;
          state_d     = (cmd_beats == 16'd0) ? ST_DONE : ST_AW;
        end
      end
      ST_AW: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) begin
          blen_d  = blen_calc;
          beat_d  = 8'(blen_calc - 9'd1);
          state_d = ST_W;
        end
      end
      ST_W: begin
        m_axi_wvalid = s_tvalid;
        s_tready     = m_axi_wready;
        m_axi_wlast  = (beat_q == 8'd0);
        if (s_tvalid && m_axi_wready) begin
          if (beat_q == 8'd0) begin
            state_d = ST_B;
          end else begin
            beat_d = beat_q - 8'd1;
          end
        end
      end
      ST_B: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          addr_d      = addr_after;
          remaining_d = rem_after;
          err_d       = err_q | resp_bad;
          state_d     = ((rem_after == 16'd0) || err_q || resp_bad) ? ST_DONE : ST_AW;
        end
      end
      ST_DONE: begin
        done     = 1'b1;
        done_err = err_q;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
